// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer: CTRL/COUNT/COMPARE/STATUS window, compare match, auto-reload, W1C flags, level irq.
// Define TIMER_PRESCALER_EN to build the prescaler; otherwise EN ticks the counter every cycle.
module mmio_timer #(
    parameter int                   BUS_WIDTH      = 32,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR      = 32'h00003000,
    parameter int                   PRESCALE_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0] write_data,
    input  logic                 write_en,
    output logic [BUS_WIDTH-1:0] read_data,
    output logic                 irq
);

    logic                 en, autoreload, irq_en, match, ovf;
    logic [BUS_WIDTH-1:0] count, compare;
    logic                 nxt_en, nxt_autoreload, nxt_irq_en, nxt_match, nxt_ovf, nxt_irq;
    logic [BUS_WIDTH-1:0] nxt_count, nxt_compare;

    logic       sel;
    logic [1:0] idx;
    logic       wr_ctrl, wr_count, wr_compare, wr_status;
    logic       tick, evt, hit, wrap, set_match, set_ovf;
    logic       unused_addr;

    assign sel         = (addr[BUS_WIDTH-1:4] == BASE_ADDR[BUS_WIDTH-1:4]);
    assign idx         = addr[3:2];
    assign unused_addr = ^addr[1:0];
    assign wr_ctrl     = write_en && sel && (idx == 2'd0);
    assign wr_count    = write_en && sel && (idx == 2'd1);
    assign wr_compare  = write_en && sel && (idx == 2'd2);
    assign wr_status   = write_en && sel && (idx == 2'd3);

`ifdef TIMER_PRESCALER_EN
    logic [PRESCALE_WIDTH-1:0] prescale, nxt_prescale, pre_cnt, nxt_pre_cnt;

    assign tick = en && (pre_cnt == prescale);

    always_comb begin
        nxt_prescale = wr_ctrl ? write_data[16 +: PRESCALE_WIDTH] : prescale;
        nxt_pre_cnt  = pre_cnt;
        if (wr_ctrl)
            nxt_pre_cnt = '0;
        else if (en)
            nxt_pre_cnt = (pre_cnt == prescale) ? '0 : pre_cnt + PRESCALE_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            prescale <= nxt_prescale;
            pre_cnt  <= nxt_pre_cnt;
        end
    end
`else
    assign tick = en;
`endif

    assign hit  = (count == compare);
    assign wrap = &count;
    // A COUNT write on a tick edge discards the tick, including any flag it would raise.
    assign evt       = tick && !wr_count;
    assign set_match = evt && hit;
    assign set_ovf   = evt && wrap && !(hit && autoreload);

    always_comb begin
        nxt_en         = wr_ctrl ? write_data[0] : en;
        nxt_autoreload = wr_ctrl ? write_data[1] : autoreload;
        nxt_irq_en     = wr_ctrl ? write_data[2] : irq_en;
        nxt_compare    = wr_compare ? write_data : compare;
        nxt_count      = count;
        if (wr_count)
            nxt_count = write_data;
        else if (tick)
            nxt_count = (hit && autoreload) ? '0 : count + BUS_WIDTH'(1);
        nxt_match = (match && !(wr_status && write_data[0])) || set_match;
        nxt_ovf   = (ovf   && !(wr_status && write_data[1])) || set_ovf;
        // irq is a flop fed from next-state so it rises on the flag-set edge without glitching.
        nxt_irq   = nxt_irq_en && (nxt_match || nxt_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en         <= 1'b0;
            autoreload <= 1'b0;
            irq_en     <= 1'b0;
            count      <= '0;
            compare    <= '0;
            match      <= 1'b0;
            ovf        <= 1'b0;
            irq        <= 1'b0;
        end else begin
            en         <= nxt_en;
            autoreload <= nxt_autoreload;
            irq_en     <= nxt_irq_en;
            count      <= nxt_count;
            compare    <= nxt_compare;
            match      <= nxt_match;
            ovf        <= nxt_ovf;
            irq        <= nxt_irq;
        end
    end

    always_comb begin
        read_data = '0;
        if (sel) begin
            case (idx)
                2'd0: begin
                    read_data[2:0] = {irq_en, autoreload, en};
`ifdef TIMER_PRESCALER_EN
                    read_data[16 +: PRESCALE_WIDTH] = prescale;
`endif
                end
                2'd1:    read_data = count;
                2'd2:    read_data = compare;
                default: read_data[1:0] = {ovf, match};
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: stimulus queues expected reads, a monitor compares on each read strobe.
`timescale 1ns/100ps
module tb_mmio_timer;

    localparam logic [31:0] A_CTRL = 32'h3000, A_COUNT = 32'h3004, A_CMP = 32'h3008, A_STAT = 32'h300C;
`ifdef TIMER_PRESCALER_EN
    localparam int          PER2    = 3;
    localparam logic [31:0] CTRL_RB = 32'hABCD0006;
`else
    localparam int          PER2    = 1;
    localparam logic [31:0] CTRL_RB = 32'h00000006;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, write_en = 1'b0, irq, rd_vld = 1'b0;
    logic [31:0] addr = '0, write_data = '0, read_data;

    typedef struct {
        bit          is_irq;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;

    mmio_timer dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
        .write_en(write_en), .read_data(read_data), .irq(irq)
    );

    always #10 clk = ~clk;

    // Monitor: one comparison per read strobe, expected value popped from the scoreboard.
    always @(posedge rd_vld) begin
        exp_t        e;
        logic [31:0] act;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL strobe with empty scoreboard");
        end else begin
            e   = sb.pop_front();
            act = e.is_irq ? {31'b0, irq} : read_data;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; write_data = d; write_en = 1'b1;
        @(posedge clk);
        #1 write_en = 1'b0;
    endtask

    task automatic chk(input logic [31:0] a, input logic [31:0] e, input string name);
        exp_t x;
        x.is_irq = 1'b0; x.exp = e; x.name = name;
        sb.push_back(x);
        addr = a;
        #1 rd_vld = 1'b1;
        #1 rd_vld = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string name);
        exp_t x;
        x.is_irq = 1'b1; x.exp = {31'b0, e}; x.name = name;
        sb.push_back(x);
        #1 rd_vld = 1'b1;
        #1 rd_vld = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values, readable while reset is held
        #1;
        chk(A_CTRL,  0, "rst_ctrl");
        chk(A_COUNT, 0, "rst_count");
        chk(A_CMP,   0, "rst_cmp");
        chk(A_STAT,  0, "rst_stat");
        chk_irq(1'b0, "rst_irq");
        chk(32'h2000, 0, "unselected");
        step();
        rst_n = 1'b1;

        // CTRL readback; unselected write has no effect
        wr(A_CTRL, 32'hABCD_FFF6);
        chk(A_CTRL, CTRL_RB, "ctrl_readback");
        wr(32'h2004, 32'h55);
        chk(A_COUNT, 0, "unsel_write");

        // Prescaled counting P=2, COMPARE=5, no autoreload
        wr(A_CMP, 5);
        wr(A_CTRL, 32'h0002_0001);
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 3 || k == 15 || k == 18) begin
                chk(A_COUNT, k / PER2, $sformatf("ps_count_k%0d", k));
                chk(A_STAT, (k / PER2 >= 6) ? 1 : 0, $sformatf("ps_stat_k%0d", k));
            end
        end
        wr(A_CTRL, 0);
        wr(A_STAT, 3);

        // Auto-reload with interrupt, P=0
        wr(A_COUNT, 0);
        wr(A_CMP, 3);
        wr(A_CTRL, 7);
        step(); chk(A_COUNT, 1, "ar_c1");
        step(); chk(A_COUNT, 2, "ar_c2");
        step(); chk(A_COUNT, 3, "ar_c3"); chk(A_STAT, 0, "ar_st_pre"); chk_irq(1'b0, "ar_irq_pre");
        step(); chk(A_COUNT, 0, "ar_reload"); chk(A_STAT, 1, "ar_match"); chk_irq(1'b1, "ar_irq");
        step(); chk(A_COUNT, 1, "ar_c5");
        wr(A_STAT, 1);
        chk(A_STAT, 0, "w1c_match"); chk_irq(1'b0, "w1c_irq"); chk(A_COUNT, 2, "w1c_count");
        step(); chk_irq(1'b0, "irq_hold0");
        step(); chk_irq(1'b1, "irq_rematch"); chk(A_COUNT, 0, "rematch_count");

        // W1C on the match edge: set wins
        wr(A_STAT, 1);
        step(); step();
        chk(A_COUNT, 3, "pre_collide");
        wr(A_STAT, 1);
        chk(A_STAT, 1, "w1c_vs_set"); chk_irq(1'b1, "w1c_vs_set_irq"); chk(A_COUNT, 0, "w1c_vs_set_cnt");

        // COUNT write on a would-be match tick: write wins, no flag
        wr(A_STAT, 1);
        step(); step();
        wr(A_COUNT, 32'h100);
        chk(A_COUNT, 32'h100, "cnt_write_wins"); chk(A_STAT, 0, "cnt_write_noflag");
        step();
        chk(A_COUNT, 32'h101, "cnt_after_write");
        wr(A_CTRL, 0);

        // Overflow wrap without IRQ_EN
        wr(A_STAT, 3);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CMP, 0);
        wr(A_CTRL, 1);
        step(); step();
        chk(A_COUNT, 0, "ovf_count"); chk(A_STAT, 2, "ovf_flag"); chk_irq(1'b0, "ovf_no_irq");
        wr(A_CTRL, 0);

        // Autoreload from all-ones: MATCH but no OVF
        wr(A_STAT, 3);
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'hFFFF_FFFF);
        wr(A_CTRL, 3);
        step(); step();
        chk(A_COUNT, 0, "ar_top_count"); chk(A_STAT, 1, "ar_top_noovf");

        // Async reset mid-count
        wr(A_CTRL, 7);
        chk_irq(1'b1, "pre_reset_irq");
        step();
        rst_n = 1'b0;
        #1;
        chk(A_COUNT, 0, "arst_count"); chk(A_CTRL, 0, "arst_ctrl");
        chk(A_STAT, 0, "arst_stat");   chk_irq(1'b0, "arst_irq");
        step();
        rst_n = 1'b1;

        #5;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that responds on the processor's data-memory bus (addr / write_data / write_en / read_data) alongside data memory. It decodes a 16-byte register window and returns read data combinationally, matching the single-cycle core's load timing. Writes commit on the rising clock edge. It implements a prescaled 32-bit up-counter with compare match, optional auto-reload, sticky status flags and a level interrupt output.

## Interface
- BUS_WIDTH, 32, data/address bus width
- BASE_ADDR, 32'h00003000, byte base of register window; bits [3:0] ignored
- PRESCALE_WIDTH, 16, prescaler width; must be ≤ 16
- clk  in  1  clock, rising-edge active
- rst_n  in  1  asynchronous, active-low reset
- addr  in  BUS_WIDTH  byte address from ALU result
- write_data  in  BUS_WIDTH  store data
- write_en  in  1  store strobe, sampled at rising clk
- read_data  out  BUS_WIDTH  register read data, combinational
- irq  out  1  interrupt request, level, active-high

## Operation
- Select: sel = (addr[31:4] == BASE_ADDR[31:4]); register index = addr[3:2]; addr[1:0] ignored.
- read_data = selected register when sel, else 0. No side effects on read.
- Registers:
  - 0x0 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN, [31:16] PRESCALE; other bits read 0.
  - 0x4 COUNT: R/W.
  - 0x8 COMPARE: R/W.
  - 0xC STATUS: bit0 MATCH, bit1 OVF; write-1-to-clear; other bits read 0.
- Prescaler: internal pre_cnt.
  - While EN=1: increments each cycle. When pre_cnt == PRESCALE, pre_cnt ← 0 and one tick is produced.
  - While EN=0: pre_cnt holds.
  - Any CTRL write forces pre_cnt ← 0.
- On tick:
  - If COUNT == COMPARE: MATCH ← 1, and COUNT ← AUTORELOAD ? 0 : COUNT+1.
  - Otherwise: COUNT ← COUNT+1.
  - Whenever the increment wraps (COUNT was 0xFFFFFFFF): OVF ← 1.
  - When AUTORELOAD reloads from 0xFFFFFFFF, OVF is not set.
- irq = IRQ_EN & (MATCH | OVF), driven from registered state; no glitches.

## Timing
- Reset: CTRL, COUNT, COMPARE, STATUS and pre_cnt are all 0; irq = 0. read_data follows addr combinationally even during reset (value 0 for all registers).
- Write latency: register value is visible on read_data the cycle after the write edge.
- Enabling: CTRL write with EN=1 and PRESCALE=P at edge E. The first tick occurs at edge E+P+1; subsequent ticks follow every P+1 cycles.
- Flag latency: MATCH/OVF are set at the tick edge; irq rises at that same edge.
- Simultaneous events:
  - COUNT write and tick on the same edge: the write wins and the tick is discarded entirely, so no flag is set by it.
  - COMPARE write and tick on the same edge: the tick compares against the old COMPARE.
  - STATUS W1C and flag set on the same edge: set wins.
- Asynchronous reset mid-count clears everything immediately; no pending tick survives.
- write_en with sel=0: no state change.

## Configuration
- TIMER_PRESCALER_EN defined: prescaler implemented as described.
- TIMER_PRESCALER_EN undefined:
  - pre_cnt removed; a tick occurs every cycle while EN=1.
  - CTRL[31:16] is not stored and reads 0.
  - All other behaviour is identical.

## Test plan
- Reset value check: assert rst_n=0, then read all four offsets at BASE_ADDR → 0x0 each; irq=0. Read at 0x00002000 (unselected) → 0.
- Prescaled counting: write COMPARE=5, then CTRL=0x0002_0001 (P=2, EN) → COUNT reads 1 three cycles after the CTRL edge, and 5 at fifteen cycles. MATCH sets on the tick where COUNT==5; COUNT then becomes 6 (no autoreload).
- Auto-reload with interrupt: COMPARE=3, CTRL=0x7 with P=0 → COUNT sequence 1,2,3,0,1…; MATCH=1 and irq=1 after the first match. Write STATUS=0x1 → MATCH=0, irq=0 until the next match.
- Overflow wrap: write COUNT=0xFFFFFFFE, COMPARE=0, CTRL=0x1 → after 2 cycles COUNT=0 and OVF=1 (STATUS reads 0x2, ignoring MATCH); irq stays 0 because IRQ_EN=0.
- Collisions:
  - Write COUNT=0x100 on a tick edge → COUNT reads 0x100 and no flag changes.
  - Write STATUS=0x1 on the edge where a match occurs → MATCH remains 1.
- Async reset mid-operation: counting with P=0, pull rst_n low between edges → COUNT, CTRL, STATUS and irq read 0 before the next clk edge.
